simeck_round_engine: RTL and testbench

- Iterative Simeck block-cipher engine. Each instance has one round-function datapath and one DATAW-bit L/R register pair, and runs both encryption and decryption.
- Runs NROUNDS rounds, one per clock, over one 2*DATAW block.
- Fetches round keys by index from an external key store.
- Uses valid/ready handshakes on input and output.
- Sits between the host block buffer and the key-schedule RAM. Replaces the fixed-direction single-round decrypt datapath.

---
 rtl/simeck_round_engine_if.sv | 36 +++
 rtl/simeck_round_engine.sv | 137 +++++++++++++
 tb/tb_simeck_round_engine.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simeck_round_engine_if.sv
// simeck_round_engine_if
//   Groups the block/key/result handshakes of the Simeck round engine.
//   master : host side (block buffer, key-schedule RAM, result consumer)
//   slave  : engine side
// Signals:
//   in_valid/in_ready, mode, in_l, in_r : input block handshake
//   rk_idx / rk                         : round-key lookup (combinational return)
//   out_valid/out_ready, out_l, out_r   : result handshake
//   busy                                : engine holds a block (RUN or DONE)
interface simeck_round_engine_if #(
  parameter int DATAW = 16,
  parameter int RKW   = 6
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [DATAW-1:0] in_l;
  logic [DATAW-1:0] in_r;
  logic [RKW-1:0]   rk_idx;
  logic [DATAW-1:0] rk;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_l;
  logic [DATAW-1:0] out_r;
  logic             busy;

  modport master (
    output in_valid, mode, in_l, in_r, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_l, out_r, busy
  );

  modport slave (
    input  in_valid, mode, in_l, in_r, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_l, out_r, busy
  );
endinterface

// File: rtl/simeck_round_engine.sv
// simeck_round_engine
//   Iterative Simeck encrypt/decrypt engine: one round per clock over a
//   2*DATAW block, with round keys fetched by index from an external store.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   abort  : (only with SIMECK_ABORT_EN defined) drop the current block
//   bus    : simeck_round_engine_if.slave (block in, key lookup, result out)
// Optional feature macro: SIMECK_ABORT_EN
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an input block, in_ready high
// S_RUN  | one round per cycle, rk_idx = round counter
// S_DONE | result held on out_l/out_r with out_valid until out_ready
module simeck_round_engine #(
  parameter int DATAW   = 16,
  parameter int NROUNDS = 32,
  parameter int RKW     = 6
) (
  input  logic clk,
  input  logic reset,
`ifdef SIMECK_ABORT_EN
  input  logic abort,
`endif
  simeck_round_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [RKW-1:0] LAST_IDX = RKW'(NROUNDS - 1);

  state_t           state_q, state_d;
  logic [RKW-1:0]   cnt_q, cnt_d;
  logic [DATAW-1:0] l_q, l_d;
  logic [DATAW-1:0] r_q, r_d;
  logic             mode_q, mode_d;

  logic [DATAW-1:0] f_in;
  logic [DATAW-1:0] f_out;
  logic [DATAW-1:0] rnd_word;
  logic             last_round;
  logic             abort_req;

`ifdef SIMECK_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
    end
  end

  // Single shared round datapath: encrypt mixes f(L) into R, decrypt mixes
  // f(R) into L, so only the operand selection depends on direction.
  always_comb begin
    f_in       = mode_q ? r_q : l_q;
    f_out      = (f_in & {f_in[DATAW-6:0], f_in[DATAW-1:DATAW-5]})
               ^ {f_in[DATAW-2:0], f_in[DATAW-1]};
    rnd_word   = (mode_q ? l_q : r_q) ^ f_out ^ bus.rk;
    last_round = mode_q ? (cnt_q == '0) : (cnt_q == LAST_IDX);

    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          l_d     = bus.in_l;
          r_d     = bus.in_r;
          mode_d  = bus.mode;
          cnt_d   = bus.mode ? LAST_IDX : '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (mode_q) begin
          l_d = r_q;
          r_d = rnd_word;
        end else begin
          l_d = rnd_word;
          r_d = l_q;
        end
        // Counter holds on its final value instead of wrapping.
        if (last_round) begin
          state_d = S_DONE;
        end else begin
          cnt_d = mode_q ? (cnt_q - RKW'(1)) : (cnt_q + RKW'(1));
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over out_ready and discards the block without presenting it.
    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      l_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.rk_idx    = (state_q == S_RUN) ? cnt_q : '0;
  // Intermediate round values never leave the block; outputs read zero
  // until the result is complete.
  assign bus.out_l     = (state_q == S_DONE) ? l_q : '0;
  assign bus.out_r     = (state_q == S_DONE) ? r_q : '0;

endmodule

// File: tb/tb_simeck_round_engine.sv
// tb_simeck_round_engine
//   Directed bench for simeck_round_engine (Simeck32/64). The bench acts as
//   host and key store: round keys come from a key-schedule model of the
//   published master key; block results are compared to the known vector.
module tb_simeck_round_engine;
  localparam int DATAW = 16;
  localparam int NR    = 32;
  localparam int RKW   = 6;

  logic clk;
  logic reset;
`ifdef SIMECK_ABORT_EN
  logic abort;
`endif
  int errors;
  int checks;
  logic [DATAW-1:0] rk_tab [0:63];

  simeck_round_engine_if #(.DATAW(DATAW), .RKW(RKW)) bus ();

  simeck_round_engine #(.DATAW(DATAW), .NROUNDS(NR), .RKW(RKW)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SIMECK_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb bus.rk = rk_tab[bus.rk_idx];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] f16(input logic [15:0] x);
    return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
  endfunction

  // Simeck32/64 key schedule for master key 1918 1110 0908 0100.
  task automatic build_keys();
    logic [15:0] ks [4];
    logic [15:0] c;
    logic [15:0] t;
    logic [31:0] seq;
    for (int i = 0; i < 64; i++) rk_tab[i] = 16'h0000;
    ks[0] = 16'h0100; ks[1] = 16'h0908; ks[2] = 16'h1110; ks[3] = 16'h1918;
    seq = 32'h9A42BB1F;
    for (int i = 0; i < NR; i++) begin
      rk_tab[i] = ks[0];
      c = 16'hFFFC | {15'd0, seq[0]};
      seq = seq >> 1;
      t = ks[1];
      ks[1] = f16(ks[1]) ^ ks[0] ^ c;
      ks[0] = t;
      t = ks[1]; ks[1] = ks[2]; ks[2] = ks[3]; ks[3] = t;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.out_l !== 16'h0000) begin errors++; $display("FAIL reset_out_l: got %h want 0000", bus.out_l); end
    checks++;
    if (bus.out_r !== 16'h0000) begin errors++; $display("FAIL reset_out_r: got %h want 0000", bus.out_r); end
    checks++;
    if (bus.rk_idx !== 6'd0) begin errors++; $display("FAIL reset_rk_idx: got %0d want 0", bus.rk_idx); end
  endtask

  // One complete block: handshake, key-index sequence, latency, result, release.
  task automatic test_vector(input string name, input logic m,
                             input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] el, input logic [15:0] er);
    int n;
    int idx_bad;
    logic [RKW-1:0] exp_idx;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    bus.in_valid = 1'b1; bus.mode = m; bus.in_l = l; bus.in_r = r;
    tick();
    bus.in_valid = 1'b0; bus.in_l = 16'h0000; bus.in_r = 16'h0000;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b in_ready=%b want busy=1 in_ready=0", name, bus.busy, bus.in_ready);
    end
    n = 0;
    idx_bad = 0;
    while (bus.out_valid !== 1'b1 && n < NR + 8) begin
      exp_idx = m ? RKW'(NR - 1 - n) : RKW'(n);
      if (bus.rk_idx !== exp_idx) idx_bad++;
      tick();
      n++;
    end
    checks++;
    if (n != NR) begin errors++; $display("FAIL %s_latency: got %0d cycles after handshake edge want %0d", name, n, NR); end
    checks++;
    if (idx_bad != 0) begin errors++; $display("FAIL %s_rk_idx: %0d wrong indices want 0", name, idx_bad); end
    checks++;
    if (bus.out_l !== el) begin errors++; $display("FAIL %s_out_l: got %h want %h", name, bus.out_l, el); end
    checks++;
    if (bus.out_r !== er) begin errors++; $display("FAIL %s_out_r: got %h want %h", name, bus.out_r, er); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b busy=%b want 1 0 0", name, bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    bus.in_valid = 1'b1; bus.mode = 1'b0; bus.in_l = 16'h6565; bus.in_r = 16'h6877;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < NR + 8) begin tick(); n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_done: out_valid=%b want 1", bus.out_valid); end
    bad = 0;
    bus.in_valid = 1'b1; bus.mode = 1'b1; bus.in_l = 16'h1234; bus.in_r = 16'h5678;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
          bus.out_l !== 16'h770d || bus.out_r !== 16'h2c76) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    checks++;
    if (bus.out_l !== 16'h770d || bus.out_r !== 16'h2c76) begin
      errors++; $display("FAIL bp_result: got %h/%h want 770d/2c76", bus.out_l, bus.out_r);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_input: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bus.in_valid = 1'b1; bus.mode = 1'b0; bus.in_l = 16'h6565; bus.in_r = 16'h6877;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx !== 6'd15 && n < NR + 8) begin tick(); n++; end
    checks++;
    if (n != 15) begin errors++; $display("FAIL rst_reach_round15: got %0d cycles want 15", n); end
    #2;
    reset = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_after_release: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    test_vector("rst_enc", 1'b0, 16'h6565, 16'h6877, 16'h770d, 16'h2c76);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int nhs;
    int nout;
    int hs_cyc [2];
    logic [15:0] res_l [2];
    logic [15:0] res_r [2];
    logic hs;
    cyc = 0; nhs = 0; nout = 0;
    hs_cyc[0] = 0; hs_cyc[1] = 0;
    res_l[0] = 16'h0; res_l[1] = 16'h0; res_r[0] = 16'h0; res_r[1] = 16'h0;
    bus.in_valid = 1'b1; bus.mode = 1'b0; bus.in_l = 16'h6565; bus.in_r = 16'h6877;
    bus.out_ready = 1'b1;
    while ((nhs < 2 || nout < 2) && cyc < 120) begin
      hs = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      if (bus.out_valid === 1'b1 && nout < 2) begin
        res_l[nout] = bus.out_l; res_r[nout] = bus.out_r; nout++;
      end
      tick();
      cyc++;
      if (hs && nhs < 2) begin
        hs_cyc[nhs] = cyc;
        nhs++;
        if (nhs == 1) begin
          bus.mode = 1'b1; bus.in_l = 16'h770d; bus.in_r = 16'h2c76;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (nhs != 2 || nout != 2) begin errors++; $display("FAIL b2b_complete: handshakes=%0d results=%0d want 2 2", nhs, nout); end
    checks++;
    if (hs_cyc[1] - hs_cyc[0] != NR + 2) begin
      errors++; $display("FAIL b2b_spacing: got %0d want %0d", hs_cyc[1] - hs_cyc[0], NR + 2);
    end
    checks++;
    if (res_l[0] !== 16'h770d || res_r[0] !== 16'h2c76) begin
      errors++; $display("FAIL b2b_enc: got %h/%h want 770d/2c76", res_l[0], res_r[0]);
    end
    checks++;
    if (res_l[1] !== 16'h6565 || res_r[1] !== 16'h6877) begin
      errors++; $display("FAIL b2b_dec: got %h/%h want 6565/6877", res_l[1], res_r[1]);
    end
  endtask

`ifdef SIMECK_ABORT_EN
  task automatic test_abort();
    int n;
    int seen;
    bus.in_valid = 1'b1; bus.mode = 1'b0; bus.in_l = 16'h6565; bus.in_r = 16'h6877;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx !== 6'd10 && n < NR + 8) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b in_ready=%b out_valid=%b want 0 1 0", bus.busy, bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < NR + 4; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_result: out_valid high %0d cycles want 0", seen); end
    test_vector("abort_next", 1'b0, 16'h6565, 16'h6877, 16'h770d, 16'h2c76);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
`ifdef SIMECK_ABORT_EN
    abort = 1'b0;
`endif
    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.in_l = 16'h0; bus.in_r = 16'h0;
    bus.out_ready = 1'b0;
    build_keys();
    #2;
    reset = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_vector("enc", 1'b0, 16'h6565, 16'h6877, 16'h770d, 16'h2c76);
    test_vector("dec", 1'b1, 16'h770d, 16'h2c76, 16'h6565, 16'h6877);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SIMECK_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
